// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with a word-serial backing-memory port.
// Define CACHE_STATS_EN to build the hit/miss counters; otherwise stat_hit/stat_miss are tied to zero.
module set_assoc_cache #(
  parameter int NUM_WAYS       = 2,
  parameter int NUM_SETS       = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        mmu_clk,
  input  logic        i_rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - OFF_W - SET_W;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND} state_t;
  state_t state_q, state_d;

  logic              we_q, err_q;
  logic [2:0]        func3_q;
  logic [31:0]       addr_q, wdata_q;
  logic [WAY_W-1:0]  way_q, hit_way, victim_way, rr_next;
  logic [CNT_W-1:0]  cnt_q, req_word;
  logic [SET_W-1:0]  req_set;
  logic [TAG_W-1:0]  req_tag, mem_tag;
  logic [31:0]       line_addr, cur_word, mem_word, merged_word, load_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              hit, victim_found, victim_dirty, misalign, last_word;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAY_W-1:0]    rr_q    [NUM_SETS];
  logic [31:0]         data_mem [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]    tag_mem  [NUM_WAYS][NUM_SETS];

  assign req_set   = addr_q[2+OFF_W +: SET_W];
  assign req_tag   = addr_q[31 -: TAG_W];
  assign last_word = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
  assign misalign  = (func3_q[1:0] == 2'b01 && addr_q[0]) || (func3_q[1] && addr_q[1:0] != 2'b00);
  assign mem_tag   = (state_q == S_WRITEBACK) ? tag_mem[way_q][req_set] : req_tag;

  generate
    if (OFF_W > 0) begin : g_multi_word
      assign req_word  = addr_q[2 +: OFF_W];
      assign line_addr = {mem_tag, req_set, cnt_q, 2'b00};
    end else begin : g_single_word
      assign req_word  = '0;
      assign line_addr = {mem_tag, req_set, 2'b00};
    end
  endgenerate

  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP:    if (misalign || hit) state_d = S_RESPOND;
                   else if (victim_dirty) state_d = S_WRITEBACK;
                   else state_d = S_REFILL;
      S_WRITEBACK: if (mem_ack && last_word) state_d = S_REFILL;
      S_REFILL:    if (mem_ack && last_word) state_d = S_RESPOND;
      S_RESPOND:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr;
        mem_wdata = mem_word;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr;
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = err_q ? '0 : load_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      we_q    <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      we_q    <= req_we;
      func3_q <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      way_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOOKUP: begin
          way_q <= hit ? hit_way : victim_way;
          cnt_q <= '0;
          err_q <= misalign;
        end
        S_WRITEBACK, S_REFILL: if (mem_ack) cnt_q <= last_word ? '0 : cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // First matching way wins; tags are unique per set so at most one can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_set][w] && tag_mem[w][req_set] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim_found = 1'b0;
    victim_way   = rr_q[req_set];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_found && !valid_q[req_set][w]) begin
        victim_found = 1'b1;
        victim_way   = WAY_W'(w);
      end
    end
  end

  assign victim_dirty = valid_q[req_set][victim_way] && dirty_q[req_set][victim_way];
  assign rr_next      = (rr_q[req_set] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[req_set] + 1'b1;

  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (state_q == S_REFILL && mem_ack && last_word) begin
        valid_q[req_set][way_q] <= 1'b1;
        dirty_q[req_set][way_q] <= 1'b0;
        rr_q[req_set]           <= rr_next;
      end
      if (state_q == S_RESPOND && we_q && !err_q) dirty_q[req_set][way_q] <= 1'b1;
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge mmu_clk) begin
    if (state_q == S_REFILL && mem_ack) begin
      data_mem[way_q][req_set][cnt_q] <= mem_rdata;
      if (last_word) tag_mem[way_q][req_set] <= req_tag;
    end
    if (state_q == S_RESPOND && we_q && !err_q) data_mem[way_q][req_set][req_word] <= merged_word;
  end

  assign cur_word = data_mem[way_q][req_set][req_word];
  assign mem_word = data_mem[way_q][req_set][cnt_q];
  assign byte_v   = cur_word[8*addr_q[1:0] +: 8];
  assign half_v   = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    merged_word = cur_word;
    case (func3_q[1:0])
      2'b00:   merged_word[8*addr_q[1:0] +: 8] = wdata_q[7:0];
      2'b01:   merged_word[16*addr_q[1] +: 16] = wdata_q[15:0];
      default: merged_word = wdata_q;
    endcase
  end

  always_comb begin
    case (func3_q)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'h0, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b101:  load_data = {16'h0, half_v};
      default: load_data = cur_word;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q;

  always_ff @(posedge mmu_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else if (state_q == S_LOOKUP && !misalign) begin
      if (hit) stat_hit_q  <= stat_hit_q + 32'd1;
      else     stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;
`else
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: responses and memory traffic checked against scoreboard queues.
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_func3 = 3'b010;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stat_hit, stat_miss;

  typedef struct { logic err; logic chk_data; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mtx_t;
  rsp_t rsp_q[$];
  mtx_t exp_mem[$];

  logic [31:0] mem_model [1024];
  logic        obs_we   [256];
  logic [31:0] obs_addr [256];
  logic [31:0] obs_data [256];
  int          obs_wr = 0;
  int          obs_rd = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          checks = 0;
  int          errors = 0;

  set_assoc_cache dut (
    .mmu_clk(clk), .i_rstn(i_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  // Backing memory: acks each word one negedge after seeing it, except the stalled address.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    mem_model[64] = 32'h11; mem_model[65] = 32'h22; mem_model[66] = 32'h33; mem_model[67] = 32'h44;
    mem_model[80] = 32'h55; mem_model[81] = 32'h66; mem_model[82] = 32'h77; mem_model[83] = 32'h88;
    mem_model[96] = 32'h99; mem_model[97] = 32'hAA; mem_model[98] = 32'hBB; mem_model[99] = 32'hCC;
    forever begin
      @(negedge clk);
      if (!i_rstn || mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && mem_addr != stall_addr) begin
        if (mem_we) mem_model[mem_addr[11:2]] = mem_wdata;
        else        mem_rdata = mem_model[mem_addr[11:2]];
        if (obs_wr < 256) begin
          obs_we[obs_wr]   = mem_we;
          obs_addr[obs_wr] = mem_addr;
          obs_data[obs_wr] = mem_we ? mem_wdata : mem_rdata;
          obs_wr++;
        end
        mem_ack = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic exp_line(input logic we, input logic [31:0] base,
                          input logic [31:0] d0, d1, d2, d3);
    mtx_t t;
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      t.we = we; t.addr = base + 32'(4 * i); t.data = d[i];
      exp_mem.push_back(t);
    end
  endtask

  task automatic check_mem(input string tag);
    mtx_t t;
    while (exp_mem.size() > 0) begin
      t = exp_mem.pop_front();
      if (obs_rd < obs_wr) begin
        chk({tag, "/mem_we"},   32'(obs_we[obs_rd]), 32'(t.we));
        chk({tag, "/mem_addr"}, obs_addr[obs_rd], t.addr);
        chk({tag, "/mem_data"}, obs_data[obs_rd], t.data);
        obs_rd++;
      end else begin
        chk({tag, "/mem_count"}, 32'(obs_wr), 32'(obs_rd + 1));
      end
    end
    chk({tag, "/mem_extra"}, 32'(obs_wr - obs_rd), 32'd0);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic chk_data,
                        input logic exp_err, input int exp_lat);
    rsp_t e;
    int   lat;
    e.err = exp_err; e.chk_data = chk_data; e.data = exp_data;
    rsp_q.push_back(e);
    @(negedge clk);
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 500) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid && rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(e.err));
      if (e.chk_data) chk({tag, "/rsp_rdata"}, rsp_rdata, e.data);
      if (exp_lat > 0) chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    end
    $display("txn %s we=%0b f3=%03b addr=0x%08h rdata=0x%08h err=%0b cycles=%0d",
             tag, we, f3, addr, rsp_rdata, rsp_err, lat);
    check_mem(tag);
  endtask

  initial begin
    int waited;
    #2;
    chk("reset/req_ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rsp_err",   32'(rsp_err),   32'd0);
    chk("reset/rsp_rdata", rsp_rdata,      32'd0);
    chk("reset/mem_req",   32'(mem_req),   32'd0);
    chk("reset/mem_addr",  mem_addr,       32'd0);
    chk("reset/stat_hit",  stat_hit,       32'd0);
    chk("reset/stat_miss", stat_miss,      32'd0);
    repeat (3) @(negedge clk);
    i_rstn = 1'b1;

    // Cold miss refill, then a hit in the same line.
    exp_line(1'b0, 32'h100, 32'h11, 32'h22, 32'h33, 32'h44);
    do_req("cold_lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h11, 1'b1, 1'b0, 0);
    do_req("hit_lw108",  1'b0, 3'b010, 32'h108, 32'h0, 32'h33, 1'b1, 1'b0, 2);
`ifdef CACHE_STATS_EN
    chk("stats/hit",  stat_hit,  32'd1);
    chk("stats/miss", stat_miss, 32'd1);
`else
    chk("stats/hit",  stat_hit,  32'd0);
    chk("stats/miss", stat_miss, 32'd0);
`endif

    // Byte/half merges and load extensions.
    do_req("sw100",     1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b0, 1'b0, 2);
    do_req("sb101",     1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 1'b0, 1'b0, 2);
    do_req("lw100",     1'b0, 3'b010, 32'h100, 32'h0, 32'h1122AB44, 1'b1, 1'b0, 2);
    do_req("lb101",     1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAB, 1'b1, 1'b0, 2);
    do_req("lbu101",    1'b0, 3'b100, 32'h101, 32'h0, 32'h000000AB, 1'b1, 1'b0, 2);
    do_req("lh100",     1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFAB44, 1'b1, 1'b0, 2);
    do_req("lhu100",    1'b0, 3'b101, 32'h100, 32'h0, 32'h0000AB44, 1'b1, 1'b0, 2);
    do_req("lh102",     1'b0, 3'b001, 32'h102, 32'h0, 32'h00001122, 1'b1, 1'b0, 2);
    do_req("f3_111",    1'b0, 3'b111, 32'h100, 32'h0, 32'h1122AB44, 1'b1, 1'b0, 2);

    // Fill way 1 cleanly, then force eviction of the dirty 0x100 line.
    exp_line(1'b0, 32'h140, 32'h55, 32'h66, 32'h77, 32'h88);
    do_req("lw140",     1'b0, 3'b010, 32'h140, 32'h0, 32'h55, 1'b1, 1'b0, 0);
    exp_line(1'b1, 32'h100, 32'h1122AB44, 32'h22, 32'h33, 32'h44);
    exp_line(1'b0, 32'h180, 32'h99, 32'hAA, 32'hBB, 32'hCC);
    do_req("evict_lw180", 1'b0, 3'b010, 32'h180, 32'h0, 32'h99, 1'b1, 1'b0, 0);
    chk("evict/mem100", mem_model[64], 32'h1122AB44);
    do_req("hit_lw140", 1'b0, 3'b010, 32'h140, 32'h0, 32'h55, 1'b1, 1'b0, 2);

    // Misaligned accesses respond with an error and change nothing.
    do_req("mis_lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b0, 1'b1, 2);
    do_req("mis_lh101", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b0, 1'b1, 2);
    do_req("mis_lhu103", 1'b0, 3'b101, 32'h103, 32'h0, 32'h0, 1'b0, 1'b1, 2);
    do_req("mis_sw181", 1'b1, 3'b010, 32'h181, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 2);
    do_req("lw180_after", 1'b0, 3'b010, 32'h180, 32'h0, 32'h99, 1'b1, 1'b0, 2);

    do_req("sh142",     1'b1, 3'b001, 32'h142, 32'h0000BEEF, 32'h0, 1'b0, 1'b0, 2);
    do_req("lw140_sh",  1'b0, 3'b010, 32'h140, 32'h0, 32'hBEEF0055, 1'b1, 1'b0, 2);
    do_req("sb143",     1'b1, 3'b000, 32'h143, 32'h00000012, 32'h0, 1'b0, 1'b0, 2);
    do_req("lw140_sb",  1'b0, 3'b010, 32'h140, 32'h0, 32'h12EF0055, 1'b1, 1'b0, 2);

    // Reset in the middle of a refill (word 2 held un-acked).
    stall_addr = 32'h108;
    exp_line(1'b1, 32'h140, 32'h12EF0055, 32'h66, 32'h77, 32'h88);
    exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: 32'h1122AB44});
    exp_mem.push_back('{we: 1'b0, addr: 32'h104, data: 32'h22});
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    waited = 0;
    while (waited < 300 && !(mem_req && !mem_we && mem_addr == 32'h108)) begin
      @(negedge clk);
      waited++;
    end
    chk("rst/reach_word2", 32'(mem_req && !mem_we && mem_addr == 32'h108), 32'd1);
    #3 i_rstn = 1'b0;
    #1;
    chk("rst/mem_req",   32'(mem_req),   32'd0);
    chk("rst/mem_addr",  mem_addr,       32'd0);
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    $display("txn reset_mid_refill mem_req=%0b mem_addr=0x%08h", mem_req, mem_addr);
    check_mem("rst");
    repeat (2) @(negedge clk);
    i_rstn = 1'b1;
    stall_addr = 32'hFFFF_FFFF;
    chk("rst/stat_hit",  stat_hit,  32'd0);
    chk("rst/stat_miss", stat_miss, 32'd0);

    exp_line(1'b0, 32'h100, 32'h1122AB44, 32'h22, 32'h33, 32'h44);
    do_req("post_rst_lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h1122AB44, 1'b1, 1'b0, 0);
    exp_line(1'b0, 32'h140, 32'h12EF0055, 32'h66, 32'h77, 32'h88);
    do_req("post_rst_lw140", 1'b0, 3'b010, 32'h140, 32'h0, 32'h12EF0055, 1'b1, 1'b0, 0);

    chk("end/rsp_queue", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
